// File: rtl/dram_bank_model.sv
// Cycle-level single-bank DRAM device: open-row buffer, tRCD/tRP spacing,
// CAS-latency read pipeline, byte-masked writes and sticky violation flags.
module dram_bank_model #(
    parameter int ROW_BITS = 11,
    parameter int COL_BITS = 10,
    parameter int TRCD     = 5,
    parameter int TRP      = 5,
    parameter int CAS_LAT  = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        DRAM_CSn,
    input  logic        DRAM_RASn,
    input  logic        DRAM_CASn,
    input  logic [3:0]  DRAM_WEn,
    input  logic [10:0] DRAM_A,
    input  logic [31:0] DRAM_D,
    output logic [31:0] DRAM_Q,
    output logic        DRAM_valid,
    output logic [3:0]  err_flags
);
    localparam int ADDR_BITS = ROW_BITS + COL_BITS;
    localparam int DEPTH     = 1 << ADDR_BITS;
    localparam int TMR_MAX   = (TRCD > TRP) ? TRCD : TRP;
    localparam int TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_ACTIVATING  = 2'd1;
    localparam logic [1:0] ST_ACTIVE      = 2'd2;
    localparam logic [1:0] ST_PRECHARGING = 2'd3;

    logic [1:0]           state_reg, state_next;
    logic [TMR_W-1:0]     timer_reg, timer_next;
    logic [ROW_BITS-1:0]  row_reg, row_next;
    logic [3:0]           err_reg, err_next;

    logic                 cmd_act, cmd_pre, cmd_read, cmd_write, cmd_illegal;
    logic                 rd_exec, wr_exec;
    logic [ADDR_BITS-1:0] word_addr;
    logic [31:0]          rd_word;
    logic [31:0]          tap_data;
    logic [CAS_LAT-1:0]   vld_reg;
    logic [31:0]          q_reg;
    logic                 valid_reg;

    // Command decode; anything not listed here is a NOP.
    always_comb begin
        cmd_act     = 1'b0;
        cmd_pre     = 1'b0;
        cmd_read    = 1'b0;
        cmd_write   = 1'b0;
        cmd_illegal = 1'b0;
        if (!DRAM_CSn) begin
            if (!DRAM_RASn && !DRAM_CASn) begin
                cmd_illegal = 1'b1;
            end else if (!DRAM_RASn) begin
                if (DRAM_WEn == 4'hF) begin
                    cmd_act = 1'b1;
                end else if (DRAM_WEn == 4'h0) begin
                    cmd_pre = 1'b1;
                end else begin
                    cmd_illegal = 1'b1;
                end
            end else if (!DRAM_CASn) begin
                if (DRAM_WEn == 4'hF) begin
                    cmd_read = 1'b1;
                end else begin
                    cmd_write = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        row_next   = row_reg;
        err_next   = err_reg;
        rd_exec    = 1'b0;
        wr_exec    = 1'b0;
        if (cmd_illegal) begin
            err_next[3] = 1'b1;
        end
        case (state_reg)
            ST_IDLE: begin
                if (cmd_act) begin
                    row_next = DRAM_A[ROW_BITS-1:0];
                    if (TRCD <= 1) begin
                        state_next = ST_ACTIVE;
                    end else begin
                        timer_next = TMR_W'(TRCD - 1);
                        state_next = ST_ACTIVATING;
                    end
                end
            end
            ST_ACTIVATING: begin
                // Leaving on the edge where the timer reads 1 makes edge ACT+TRCD the first legal column edge.
                if (timer_reg <= TMR_W'(1)) begin
                    state_next = ST_ACTIVE;
                end else begin
                    timer_next = timer_reg - TMR_W'(1);
                end
                if (cmd_read || cmd_write) begin
                    err_next[1] = 1'b1;
                end
                if (cmd_act || cmd_pre) begin
                    err_next[2] = 1'b1;
                end
            end
            ST_ACTIVE: begin
                rd_exec = cmd_read;
                wr_exec = cmd_write;
                if (cmd_act) begin
                    err_next[0] = 1'b1;
                end
                if (cmd_pre) begin
                    if (TRP <= 1) begin
                        state_next = ST_IDLE;
                    end else begin
                        timer_next = TMR_W'(TRP - 1);
                        state_next = ST_PRECHARGING;
                    end
                end
            end
            ST_PRECHARGING: begin
                if (timer_reg <= TMR_W'(1)) begin
                    state_next = ST_IDLE;
                end else begin
                    timer_next = timer_reg - TMR_W'(1);
                end
                if (cmd_act) begin
                    err_next[0] = 1'b1;
                end
                if (cmd_read || cmd_write) begin
                    err_next[1] = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            timer_reg <= '0;
            row_reg   <= '0;
            err_reg   <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            row_reg   <= row_next;
            err_reg   <= err_next;
        end
    end

    assign word_addr = {row_reg, DRAM_A[COL_BITS-1:0]};

    // One RAM per byte lane so masked writes map onto plain byte-wide block RAMs.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] rd_byte_reg;
        logic       lane_we;

        assign lane_we = wr_exec && rst_n && !DRAM_WEn[gi];

        always_ff @(posedge clk) begin
            if (lane_we) begin
                lane_mem[word_addr] <= DRAM_D[8*gi +: 8];
            end
            rd_byte_reg <= lane_mem[word_addr];
        end

        assign rd_word[8*gi +: 8] = rd_byte_reg;
    end

    // The RAM output register is the first latency stage; CAS_LAT-1 more follow.
    if (CAS_LAT == 1) begin : g_no_delay
        assign tap_data = rd_word;
    end else begin : g_delay
        logic [31:0] dly_reg [CAS_LAT-1];

        always_ff @(posedge clk) begin
            dly_reg[0] <= rd_word;
            for (int s = 1; s < CAS_LAT - 1; s++) begin
                dly_reg[s] <= dly_reg[s-1];
            end
        end

        assign tap_data = dly_reg[CAS_LAT-2];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_reg   <= '0;
            valid_reg <= 1'b0;
            q_reg     <= '0;
        end else begin
            vld_reg[0] <= rd_exec;
            for (int s = 1; s < CAS_LAT; s++) begin
                vld_reg[s] <= vld_reg[s-1];
            end
            valid_reg <= vld_reg[CAS_LAT-1];
            q_reg     <= vld_reg[CAS_LAT-1] ? tap_data : 32'h0;
        end
    end

    assign DRAM_Q     = q_reg;
    assign DRAM_valid = valid_reg;
    assign err_flags  = err_reg;

endmodule

// File: tb/tb_dram_bank_model.sv
// Self-checking bench for dram_bank_model: directed vector table, a burst/reset
// sequence, and random commands checked against an edge-counting reference model.
module tb_dram_bank_model;
    localparam int TRCD    = 5;
    localparam int TRP     = 5;
    localparam int CAS_LAT = 5;

    localparam int C_NOP     = 0;
    localparam int C_ACT     = 1;
    localparam int C_PRE     = 2;
    localparam int C_RD      = 3;
    localparam int C_WR      = 4;
    localparam int C_ILL     = 5;
    localparam int C_ILL_CS1 = 6;
    localparam int C_ILL_WEN = 7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csn, rasn, casn;
    logic [3:0]  wen;
    logic [10:0] a;
    logic [31:0] d;
    logic [31:0] q;
    logic        valid;
    logic [3:0]  err;

    int n_checks = 0;
    int n_errors = 0;

    dram_bank_model #(
        .ROW_BITS(11), .COL_BITS(10), .TRCD(TRCD), .TRP(TRP), .CAS_LAT(CAS_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .DRAM_CSn(csn), .DRAM_RASn(rasn), .DRAM_CASn(casn), .DRAM_WEn(wen),
        .DRAM_A(a), .DRAM_D(d), .DRAM_Q(q), .DRAM_valid(valid), .err_flags(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        int          cmd;
        logic [10:0] a;
        logic [31:0] d;
        logic [3:0]  wen;
        bit          ev;
        logic [31:0] eq;
        logic [3:0]  eerr;
    } vec_t;
    vec_t vecs[$];

    typedef struct {
        int          due;
        logic [31:0] data;
        logic [31:0] mask;
    } rd_t;

    // Reference model state: edge numbers rather than counters.
    int          cyc;
    bit          m_open;
    int          m_act_edge, m_pre_edge;
    logic [10:0] m_row;
    logic [3:0]  m_err;
    logic [31:0] m_mem [int];
    logic [3:0]  m_known [int];
    rd_t         m_rdq[$];
    bit          exp_v;
    logic [31:0] exp_q, exp_mask;

    function automatic void add(input bit r, input int c, input logic [10:0] aa,
                                input logic [31:0] dd, input logic [3:0] ww,
                                input bit ev, input logic [31:0] eq, input logic [3:0] ee);
        vec_t v;
        v.rst = r; v.cmd = c; v.a = aa; v.d = dd; v.wen = ww;
        v.ev = ev; v.eq = eq; v.eerr = ee;
        vecs.push_back(v);
    endfunction

    function automatic void nops(input int n, input logic [3:0] ee);
        for (int i = 0; i < n; i++) add(1, C_NOP, 11'h0, 32'h0, 4'hF, 0, 32'h0, ee);
    endfunction

    task automatic drive(input bit r, input int c, input logic [10:0] aa,
                         input logic [31:0] dd, input logic [3:0] ww);
        rst_n = r; csn = 1'b1; rasn = 1'b1; casn = 1'b1; wen = 4'hF; a = aa; d = dd;
        case (c)
            C_ACT:     begin csn = 1'b0; rasn = 1'b0; end
            C_PRE:     begin csn = 1'b0; rasn = 1'b0; wen = 4'h0; end
            C_RD:      begin csn = 1'b0; casn = 1'b0; end
            C_WR:      begin csn = 1'b0; casn = 1'b0; wen = ww; end
            C_ILL:     begin csn = 1'b0; rasn = 1'b0; casn = 1'b0; wen = ww; end
            C_ILL_CS1: begin rasn = 1'b0; casn = 1'b0; wen = ww; end
            C_ILL_WEN: begin csn = 1'b0; rasn = 1'b0; wen = ww; end
            default:   ;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input bit ev, input logic [31:0] eq,
                                 input logic [31:0] mask, input logic [3:0] ee);
        check({tag, ".valid"}, 32'(valid), 32'(ev));
        check({tag, ".q"}, q & mask, eq & mask);
        check({tag, ".err"}, 32'(err), 32'(ee));
    endtask

    task automatic model_edge(input bit r, input int c, input logic [10:0] aa,
                              input logic [31:0] dd, input logic [3:0] ww);
        bit activating, precharging;
        int addr;
        rd_t rd;
        cyc++;
        if (!r) begin
            m_open = 0; m_act_edge = -100; m_pre_edge = -100; m_err = 4'h0;
            m_rdq.delete();
        end else begin
            activating  = m_open && (cyc < m_act_edge + TRCD);
            precharging = !m_open && (cyc < m_pre_edge + TRP);
            addr = {11'd0, m_row, aa[9:0]};
            case (c)
                C_ILL, C_ILL_WEN: m_err[3] = 1'b1;
                C_ACT: begin
                    if (activating) m_err[2] = 1'b1;
                    else if (m_open || precharging) m_err[0] = 1'b1;
                    else begin m_open = 1; m_row = aa; m_act_edge = cyc; end
                end
                C_PRE: begin
                    if (activating) m_err[2] = 1'b1;
                    else if (m_open) begin m_open = 0; m_pre_edge = cyc; end
                end
                C_RD, C_WR: begin
                    if (activating || precharging) m_err[1] = 1'b1;
                    else if (m_open && c == C_RD) begin
                        rd.due = cyc + CAS_LAT;
                        rd.data = m_mem.exists(addr) ? m_mem[addr] : 32'h0;
                        rd.mask = 32'h0;
                        for (int b = 0; b < 4; b++)
                            if (m_known.exists(addr) && m_known[addr][b]) rd.mask[8*b +: 8] = 8'hFF;
                        m_rdq.push_back(rd);
                    end else if (m_open) begin
                        if (!m_mem.exists(addr)) begin m_mem[addr] = 32'h0; m_known[addr] = 4'h0; end
                        for (int b = 0; b < 4; b++) begin
                            if (!ww[b]) begin
                                m_mem[addr][8*b +: 8] = dd[8*b +: 8];
                                m_known[addr][b] = 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
        exp_v = 0; exp_q = 32'h0; exp_mask = 32'hFFFF_FFFF;
        if (m_rdq.size() > 0 && m_rdq[0].due == cyc) begin
            rd = m_rdq.pop_front();
            exp_v = 1; exp_q = rd.data; exp_mask = rd.mask;
        end
    endtask

    logic [10:0] row_pool [3] = '{11'h000, 11'h001, 11'h7FF};
    logic [9:0]  col_pool [5] = '{10'h000, 10'h001, 10'h002, 10'h003, 10'h3FF};

    initial begin
        // Directed table: each entry is one edge, expectations hold just after it.
        add(0, C_NOP, 11'h0, 32'h0, 4'hF, 0, 32'h0, 4'h0);
        add(0, C_NOP, 11'h0, 32'h0, 4'hF, 0, 32'h0, 4'h0);
        add(1, C_ACT, 11'h0A3, 32'h0, 4'hF, 0, 32'h0, 4'h0);
        nops(4, 4'h0);
        add(1, C_WR, 11'h3FF, 32'hCAFE_F00D, 4'h0, 0, 32'h0, 4'h0);
        add(1, C_PRE, 11'h0, 32'h0, 4'h0, 0, 32'h0, 4'h0);
        nops(4, 4'h0);
        add(1, C_ACT, 11'h005, 32'h0, 4'hF, 0, 32'h0, 4'h0);
        nops(4, 4'h0);
        add(1, C_WR, 11'h010, 32'hDEAD_BEEF, 4'h0, 0, 32'h0, 4'h0);
        add(1, C_RD, 11'h010, 32'h0, 4'hF, 0, 32'h0, 4'h0);
        nops(4, 4'h0);
        add(1, C_NOP, 11'h0, 32'h0, 4'hF, 1, 32'hDEAD_BEEF, 4'h0);
        add(1, C_WR, 11'h010, 32'h1122_3344, 4'b1010, 0, 32'h0, 4'h0);
        add(1, C_RD, 11'h410, 32'h0, 4'hF, 0, 32'h0, 4'h0);
        nops(4, 4'h0);
        add(1, C_NOP, 11'h0, 32'h0, 4'hF, 1, 32'hDE22_BE44, 4'h0);
        add(1, C_ACT, 11'h0A3, 32'h0, 4'hF, 0, 32'h0, 4'b0001);
        add(1, C_PRE, 11'h0, 32'h0, 4'h0, 0, 32'h0, 4'b0001);
        nops(3, 4'b0001);
        add(1, C_ACT, 11'h005, 32'h0, 4'hF, 0, 32'h0, 4'b0001);
        add(1, C_ACT, 11'h0A3, 32'h0, 4'hF, 0, 32'h0, 4'b0001);
        nops(4, 4'b0001);
        add(1, C_RD, 11'h3FF, 32'h0, 4'hF, 0, 32'h0, 4'b0001);
        add(1, C_ILL, 11'h0, 32'h0, 4'hF, 0, 32'h0, 4'b1001);
        add(1, C_ILL_CS1, 11'h0, 32'h0, 4'hF, 0, 32'h0, 4'b1001);
        add(1, C_RD, 11'h3FF, 32'h0, 4'hF, 0, 32'h0, 4'b1001);
        add(1, C_PRE, 11'h0, 32'h0, 4'h0, 0, 32'h0, 4'b1001);
        add(1, C_NOP, 11'h0, 32'h0, 4'hF, 1, 32'hCAFE_F00D, 4'b1001);
        nops(2, 4'b1001);
        add(1, C_NOP, 11'h0, 32'h0, 4'hF, 1, 32'hCAFE_F00D, 4'b1001);
        add(0, C_NOP, 11'h0, 32'h0, 4'hF, 0, 32'h0, 4'h0);
        add(1, C_ACT, 11'h005, 32'h0, 4'hF, 0, 32'h0, 4'h0);
        nops(3, 4'h0);
        add(1, C_RD, 11'h010, 32'h0, 4'hF, 0, 32'h0, 4'b0010);
        add(1, C_RD, 11'h010, 32'h0, 4'hF, 0, 32'h0, 4'b0010);
        nops(4, 4'b0010);
        add(1, C_NOP, 11'h0, 32'h0, 4'hF, 1, 32'hDE22_BE44, 4'b0010);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].cmd, vecs[i].a, vecs[i].d, vecs[i].wen);
            $display("vec %0d rst=%b cmd=%0d a=%h -> valid=%b q=%h err=%b",
                     i, vecs[i].rst, vecs[i].cmd, vecs[i].a, valid, q, err);
            check_outputs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eq, 32'hFFFF_FFFF, vecs[i].eerr);
        end

        // Burst of four reads, with reset landing after the second pulse.
        drive(0, C_NOP, 11'h0, 32'h0, 4'hF);
        drive(1, C_ACT, 11'h005, 32'h0, 4'hF);
        repeat (4) drive(1, C_NOP, 11'h0, 32'h0, 4'hF);
        for (int i = 0; i < 4; i++) drive(1, C_WR, 11'(i), 32'hB0B0_0000 + 32'(i), 4'h0);
        for (int i = 0; i < 4; i++) drive(1, C_RD, 11'(i), 32'h0, 4'hF);
        drive(1, C_NOP, 11'h0, 32'h0, 4'hF);
        check_outputs("burst.pre", 0, 32'h0, 32'hFFFF_FFFF, 4'h0);
        for (int i = 0; i < 2; i++) begin
            drive(1, C_NOP, 11'h0, 32'h0, 4'hF);
            $display("burst pulse %0d valid=%b q=%h", i, valid, q);
            check_outputs($sformatf("burst.p%0d", i), 1, 32'hB0B0_0000 + 32'(i), 32'hFFFF_FFFF, 4'h0);
        end
        for (int i = 0; i < 8; i++) begin
            drive(i >= 2, C_NOP, 11'h0, 32'h0, 4'hF);
            $display("burst after-reset %0d valid=%b q=%h err=%b", i, valid, q, err);
            check_outputs($sformatf("burst.rst%0d", i), 0, 32'h0, 32'hFFFF_FFFF, 4'h0);
        end

        // Random commands against the reference model.
        cyc = 0;
        drive(0, C_NOP, 11'h0, 32'h0, 4'hF);
        model_edge(0, C_NOP, 11'h0, 32'h0, 4'hF);
        for (int n = 0; n < 600; n++) begin
            int pick, c;
            bit r;
            logic [10:0] aa;
            logic [31:0] dd;
            logic [3:0] ww;
            pick = $urandom_range(99);
            r = 1; dd = $urandom; ww = 4'hF;
            aa = {1'($urandom_range(1)), col_pool[$urandom_range(4)]};
            if (pick < 2) begin r = 0; c = C_NOP; end
            else if (pick < 32) c = C_NOP;
            else if (pick < 45) begin c = C_ACT; aa = row_pool[$urandom_range(2)]; end
            else if (pick < 55) c = C_PRE;
            else if (pick < 75) c = C_RD;
            else if (pick < 93) begin c = C_WR; ww = 4'($urandom_range(14)); end
            else if (pick < 96) begin c = C_ILL; ww = 4'($urandom_range(15)); end
            else if (pick < 98) begin c = C_ILL_WEN; ww = 4'($urandom_range(14, 1)); end
            else begin c = C_ILL_CS1; ww = 4'($urandom_range(15)); end
            drive(r, c, aa, dd, ww);
            model_edge(r, c, aa, dd, ww);
            $display("rnd %0d rst=%b cmd=%0d a=%h d=%h wen=%b -> valid=%b q=%h err=%b",
                     n, r, c, aa, dd, ww, valid, q, err);
            check_outputs($sformatf("rnd%0d", n), exp_v, exp_q, exp_mask, m_err);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dram_bank_model.md
Name: dram_bank_model

Overview:
- Cycle-level single-bank DRAM device that sits directly downstream of the AXI DRAM wrapper.
- Consumes the wrapper's CSn/RASn/CASn/WEn/A/D command bus and returns Q/VALID.
- Models the open-row buffer, tRCD and tRP spacing, CAS-latency read pipeline and byte-masked writes.
- Flags protocol violations so wrapper timing is checked in simulation.

Parameters:
- ROW_BITS, 11, row address width; taken from A[ROW_BITS-1:0] on ACT.
- COL_BITS, 10, column (word) address width; taken from A[COL_BITS-1:0] on READ/WRITE.
- TRCD, 5, minimum cycles from ACT edge to the first legal READ/WRITE edge.
- TRP, 5, minimum cycles from PRE edge to the next legal ACT edge.
- CAS_LAT, 5, cycles from READ edge to the edge that asserts VALID; range 1..15.

Ports:
- clk  input  1  clock, all activity on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- DRAM_CSn  input  1  chip select, active low; 1 = NOP.
- DRAM_RASn  input  1  row strobe, active low.
- DRAM_CASn  input  1  column strobe, active low.
- DRAM_WEn  input  4  per-byte write enable, active low; bit i = byte i.
- DRAM_A  input  11  row/column address.
- DRAM_D  input  32  write data.
- DRAM_Q  output  32  read data; 0 when DRAM_valid=0.
- DRAM_valid  output  1  read data valid, one-cycle pulse per READ.
- err_flags  output  4  sticky violation flags; cleared only by reset.

Behaviour:
- Reset: Q=0, valid=0, err_flags=0, state IDLE, read pipeline flushed, row register 0. Memory array is not reset. Reset mid-operation drops in-flight reads with no VALID pulse.
- Command decode at rising edge, CSn=0:
  - ACT: RASn=0, CASn=1, WEn=1111.
  - PRE: RASn=0, CASn=1, WEn=0000.
  - READ: RASn=1, CASn=0, WEn=1111.
  - WRITE: RASn=1, CASn=0, WEn!=1111.
  - Illegal: RASn=0 and CASn=0, or RASn=0 with a partial WEn. Sets err_flags[3]; ignored.
  - Everything else: NOP.
- State machine:
  - IDLE: ACT latches row=A[ROW_BITS-1:0], loads timer=TRCD-1, goes to ACTIVATING. If TRCD<=1, goes directly to ACTIVE. PRE is a NOP.
  - ACTIVATING: timer decrements each cycle; at 0 goes to ACTIVE. A READ/WRITE here sets err[1] and is ignored. ACT or PRE here sets err[2] and is ignored.
  - ACTIVE: READ/WRITE execute. PRE loads timer=TRP-1 and goes to PRECHARGING (straight to IDLE if TRP<=1). ACT sets err[0] (row already open) and is ignored.
  - PRECHARGING: timer decrements; at 0 goes to IDLE. ACT sets err[0]; READ/WRITE set err[1]; all are ignored.
- Word address = {row, A[COL_BITS-1:0]}. A bits above COL_BITS are ignored on column commands.
- WRITE: at the command edge, byte i of the word is replaced by D[8i+7:8i] when WEn[i]=0. Other bytes are kept.
- READ:
  - Word is sampled at the command edge, after any same-edge effects. A READ one cycle after a WRITE to the same word returns the new data.
  - Data enters a CAS_LAT-deep shift pipeline. Q/VALID are registered: READ at edge k gives VALID=1 and Q=word after edge k+CAS_LAT, for exactly one cycle.
  - Back-to-back READs on consecutive edges give consecutive VALID pulses, in order.
  - A PRE issued while reads are in flight does not cancel them.
- Timing boundary: with TRCD=5 and ACT at edge k, READ/WRITE at edge k+5 is legal and at edge k+4 is an error. The same rule applies to TRP for ACT after PRE.
- err_flags are OR-accumulated and never self-clear.

Test Plan:
- Reset, ACT row 0x005 at edge 0, WRITE col 0x010 D=0xDEADBEEF WEn=0000 at edge 5, READ col 0x010 at edge 6 -> VALID=1 and Q=0xDEADBEEF after edge 11 only; err_flags=0.
- Byte mask: prior word 0xDEADBEEF, WRITE D=0x11223344 WEn=1010, then READ -> Q=0xDE22BE44.
- tRCD violation: ACT at edge 0, READ at edge 4 -> no VALID, err_flags=4'b0010. A READ at edge 5 then returns data normally.
- Row conflict and tRP: ACT in ACTIVE -> err[0]. Then PRE at edge j and ACT at edge j+4 -> err[0] stays set and the ACT is ignored. ACT at j+5 opens the new row; a READ of an address written earlier in that row returns the stored word.
- Burst: four READs on consecutive edges to cols 0..3 -> four consecutive VALID pulses with the words in order. Assert rst_n=0 after the second pulse -> remaining pulses suppressed, Q=0, err_flags=0.
- Illegal encoding: CSn=0, RASn=0, CASn=0 -> err_flags[3]=1, row state unchanged. The same encoding with CSn=1 -> no effect.
